dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder for the RV32 core's load/store port. Accepts one request at a time over a valid/ready handshake and adds configurable wait states. Performs byte/half/word writes with byte-lane enables. Returns load data already lane-extracted and sign- or zero-extended per funct3. Sits between the core's load/store unit and a word-organised SRAM array held inside the block.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; legal word index 0..DEPTH_WORDS-1
WAIT_CYCLES, 2, extra cycles between request accept and memory access (0 allowed)
ADDR_W, 32, request byte-address width

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size, or out-of-range access
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, immediate): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter 0. Array contents are not reset.
- FSM states and transitions:
  - IDLE -> WAIT on req_valid & req_ready. Latch addr, size, we, wdata. Counter loads WAIT_CYCLES.
  - WAIT: while counter != 0, decrement. When counter == 0, perform the access on that edge and go to RESP.
  - RESP: rsp_valid=1, holding rdata and err stable. On rsp_ready go to IDLE; req_ready is high the next cycle.
- Latency: accept at edge T, so rsp_valid rises after edge T+WAIT_CYCLES+1. Throughput is one transaction per WAIT_CYCLES+3 cycles minimum.
- Error checks, evaluated on latched fields:
  - size in {011, 110, 111} is an error.
  - Half access (001/101) with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - addr[ADDR_W-1:2] >= DEPTH_WORDS is an error.
  - On error: no array write, rsp_err=1, rsp_rdata=0.
- Store, with lane = addr[1:0]:
  - byte: enable lane only; data = wdata[7:0] replicated to all lanes.
  - half: enable lanes {addr[1],0} and {addr[1],1}; data = wdata[15:0] replicated.
  - word: all four lanes.
  - Unenabled bytes are unchanged. rsp_rdata=0.
- Load, extracting from the addressed word:
  - b: sign-extend bit 7 of the selected byte.
  - bu: zero-extend.
  - h: sign-extend bit 15 of the selected half.
  - hu: zero-extend.
  - w: the full word.
- Read-after-write: a load issued immediately after a store to the same word returns the new data; the array is written before the next access edge.
- req_valid seen outside IDLE is ignored (req_ready=0). The request must be held until accepted.
- rsp_ready while not in RESP has no effect.
- Reset mid-WAIT: transaction dropped, no write committed. Reset on the access edge: write is not committed, because async reset dominates.

Decomposition:
- Shared package rv32_mem_pkg:
  - size constants SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101
  - state enum IDLE/WAIT/RESP
  - function is_misaligned(size, addr[1:0])
- Combinational sub-module dmem_lane_align:
  - store side: (size, addr[1:0], wdata) -> (byte_en[3:0], lane_wdata[31:0])
  - load side: (size, addr[1:0], word) -> extended rdata
- The top holds the FSM, counter, latches and array.

Test Plan:
- Store sw 0x00000010 <- 0xDEADBEEF, then lw 0x10 with WAIT_CYCLES=2 -> rsp_valid rises exactly 3 cycles after accept; rdata=0xDEADBEEF, err=0.
- sb 0x11 <- 0x7F, then lb 0x11 -> 0x0000007F. Then lw 0x10 -> 0xDEAD7FEF.
- Over word 0x10 = 0xDEAD7FEF:
  - lh 0x12 -> 0xFFFFDEAD
  - lhu 0x12 -> 0x0000DEAD
  - lb 0x13 -> 0xFFFFFFDE
  - lbu 0x13 -> 0x000000DE
- Error cases:
  - sh 0x13 -> err=1, rdata=0, word 0x10 unchanged.
  - lw 0x4*DEPTH_WORDS -> err=1.
  - size 011 -> err=1.
- Handshake backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable; req_ready=0 throughout. After rsp_ready=1, req_ready=1 next cycle. Repeat with WAIT_CYCLES=0 -> rsp_valid 1 cycle after accept.
- Assert rst 1 cycle into WAIT of sw 0x20 <- 0x12345678 -> outputs at reset values immediately. A later lw 0x20 returns the prior value, showing no write was committed.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32_mem_pkg
// Brief   : Shared RV32 load/store size codes, responder states, access checks
// Revision: 1.0
// ============================================================================
package rv32_mem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic w_mis;
      w_mis = 1'b0;
      case (size)
         SZ_H, SZ_HU: w_mis = addr_lo[0];
         SZ_W:        w_mis = (addr_lo != 2'b00);
         default:     w_mis = 1'b0;
      endcase
      return w_mis;
   endfunction

   // 011, 110 and 111 have no RV32 load/store meaning
   function automatic logic is_bad_size(input logic [2:0] size);
      return (size == 3'b011) || (size[2:1] == 2'b11);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_align
// Brief   : Store lane steering/byte enables and load lane extract/extend
// Revision: 1.0
// ============================================================================
module dmem_lane_align
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] lane_wdata,
   output logic [31:0] rdata
);

   logic [15:0] w_sel_half;
   logic [7:0]  w_sel_byte;

   always_comb begin
      byte_en    = 4'b0000;
      lane_wdata = 32'h0000_0000;
      case (size)
         SZ_B, SZ_BU: begin
            byte_en    = 4'b0001 << addr_lo;
            lane_wdata = {4{wdata[7:0]}};
         end
         SZ_H, SZ_HU: begin
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata[15:0]}};
         end
         SZ_W: begin
            byte_en    = 4'b1111;
            lane_wdata = wdata;
         end
         default: ;
      endcase
   end

   assign w_sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
   assign w_sel_byte = addr_lo[0] ? w_sel_half[15:8] : w_sel_half[7:0];

   always_comb begin
      rdata = 32'h0000_0000;
      case (size)
         SZ_B:    rdata = {{24{w_sel_byte[7]}}, w_sel_byte};
         SZ_BU:   rdata = {24'h00_0000, w_sel_byte};
         SZ_H:    rdata = {{16{w_sel_half[15]}}, w_sel_half};
         SZ_HU:   rdata = {16'h0000, w_sel_half};
         SZ_W:    rdata = rword;
         default: rdata = 32'h0000_0000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : RV32 data-memory responder with wait states and an internal array
// Revision: 1.0
// ============================================================================
module dmem_responder
   import rv32_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_size,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int c_CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W-3:0]  c_DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);
   localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(WAIT_CYCLES);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_size;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;
   logic [31:0]         r_mem [DEPTH_WORDS];

   logic                w_accept;
   logic                w_access;
   logic                w_err;
   logic                w_mem_we;
   logic [c_IDX_W-1:0]  w_idx;
   logic [3:0]          w_byte_en;
   logic [31:0]         w_lane_wdata;
   logic [31:0]         w_rword;
   logic [31:0]         w_load_data;

   assign w_accept = (r_state == IDLE) && req_valid;
   assign w_access = (r_state == WAIT) && (r_cnt == '0);
   assign w_err    = is_bad_size(r_size)
                   | is_misaligned(r_size, r_addr[1:0])
                   | (r_addr[ADDR_W-1:2] >= c_DEPTH_LIM);
   assign w_mem_we = w_access && r_we && !w_err;
   assign w_idx    = r_addr[c_IDX_W+1:2];
   assign w_rword  = r_mem[w_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) w_state_nxt = WAIT;
         end
         WAIT: if (r_cnt == '0) w_state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_size      <= 3'b000;
         r_wdata     <= 32'h0000_0000;
         r_rsp_rdata <= 32'h0000_0000;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_wdata <= req_wdata;
            r_cnt   <= c_WAIT_LOAD;
         end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
         end

         if (w_access) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? 32'h0000_0000 : w_load_data;
         end else if ((r_state == RESP) && rsp_ready) begin
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
         end
      end
   end

   // Gating on rst keeps a reset that coincides with the access edge from committing
   always_ff @(posedge clk) begin
      if (w_mem_we && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (w_byte_en[i]) r_mem[w_idx][8*i +: 8] <= w_lane_wdata[8*i +: 8];
         end
      end
   end

   dmem_lane_align u_lane_align (
      .size       (r_size),
      .addr_lo    (r_addr[1:0]),
      .wdata      (r_wdata),
      .rword      (w_rword),
      .byte_en    (w_byte_en),
      .lane_wdata (w_lane_wdata),
      .rdata      (w_load_data)
   );

   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
